inv_pi_walker: RTL and testbench

INV_PI_WALKER -- requirements
Module: inv_pi_walker

---
 rtl/inv_pi_walker.sv | 151 +++++++++++++++
 tb/tb_inv_pi_walker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/inv_pi_walker.sv
// Inverse lane walker: starting from (x,y) it emits one beat per step t = tStart-1 .. 0,
// applying the inverse of the forward lane step after every accepted beat.
module inv_pi_walker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] tStart,
  input  logic [2:0] xInit,
  input  logic [2:0] yInit,
  input  logic       outReady,
  output logic       outValid,
  output logic [4:0] laneIdx,
  output logic [5:0] rotOff,
  output logic [4:0] stepT,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [4:0] t_q, t_d;

  logic       outValid_q, outValid_d;
  logic [4:0] laneIdx_q, laneIdx_d;
  logic [5:0] rotOff_q, rotOff_d;
  logic [4:0] stepT_q, stepT_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       walk_d;

  function automatic logic [2:0] mod5_3(input logic [2:0] v);
    return 3'(v % 3'd5);
  endfunction

  function automatic logic [4:0] lane_of(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] xs;
    logic [4:0] ys;
    xs = 5'(({2'b00, x} + 5'd2) % 5'd5);
    ys = 5'(({2'b00, y} + 5'd2) % 5'd5);
    return 5'd24 - (ys * 5'd5 + xs);
  endfunction

  // Triangular number of (t+1); the product needs 10 bits before halving.
  function automatic logic [5:0] rot_of(input logic [4:0] t);
    logic [9:0] prod;
    prod = ({5'd0, t} + 10'd1) * ({5'd0, t} + 10'd2);
    return 6'(prod >> 1);
  endfunction

  function automatic logic [2:0] inv_x(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] sum;
    sum = {2'b00, x} + 5'd3 * {2'b00, y};
    return 3'(sum % 5'd5);
  endfunction

  // FSM and walk-coordinate next state
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((tStart != 5'd0) && (tStart <= 5'd24)) begin
            x_d     = mod5_3(xInit);
            y_d     = mod5_3(yInit);
            t_d     = tStart - 5'd1;
            state_d = ST_WALK;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (outValid_q && outReady) begin
          if (t_q != 5'd0) begin
            t_d = t_q - 5'd1;
            x_d = inv_x(x_q, y_q);
            y_d = x_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next state so they can be registered without extra latency
  always_comb begin
    walk_d     = (state_d == ST_WALK);
    outValid_d = walk_d;
    busy_d     = walk_d;
    done_d     = (state_d == ST_DONE);
    if (walk_d) begin
      laneIdx_d = lane_of(x_d, y_d);
      rotOff_d  = rot_of(t_d);
      stepT_d   = t_d;
    end else begin
      laneIdx_d = 5'd0;
      rotOff_d  = 6'd0;
      stepT_d   = 5'd0;
    end
  end

  // State, coordinate and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      x_q        <= 3'd0;
      y_q        <= 3'd0;
      t_q        <= 5'd0;
      outValid_q <= 1'b0;
      laneIdx_q  <= 5'd0;
      rotOff_q   <= 6'd0;
      stepT_q    <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      t_q        <= t_d;
      outValid_q <= outValid_d;
      laneIdx_q  <= laneIdx_d;
      rotOff_q   <= rotOff_d;
      stepT_q    <= stepT_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign outValid = outValid_q;
  assign laneIdx  = laneIdx_q;
  assign rotOff   = rotOff_q;
  assign stepT    = stepT_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_pi_walker.sv
// Directed bench for inv_pi_walker: stimulus changes and sampling both happen on the falling edge.
module tb_inv_pi_walker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] tStart;
  logic [2:0] xInit;
  logic [2:0] yInit;
  logic       outReady;
  logic       outValid;
  logic [4:0] laneIdx;
  logic [5:0] rotOff;
  logic [4:0] stepT;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  // Forward orbit of (1,0): position at step t of a 24-beat walk started at (1,1)
  int orb_x[24] = '{1, 0, 2, 1, 2, 3, 3, 0, 1, 3, 1, 4, 4, 0, 3, 4, 3, 2, 2, 0, 4, 2, 4, 1};
  int orb_y[24] = '{0, 2, 1, 2, 3, 3, 0, 1, 3, 1, 4, 4, 0, 3, 4, 3, 2, 2, 0, 4, 2, 4, 1, 1};

  inv_pi_walker dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tStart   (tStart),
    .xInit    (xInit),
    .yInit    (yInit),
    .outReady (outReady),
    .outValid (outValid),
    .laneIdx  (laneIdx),
    .rotOff   (rotOff),
    .stepT    (stepT),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_walk(input int t, input int x, input int y);
    start  = 1'b1;
    tStart = 5'(t);
    xInit  = 3'(x);
    yInit  = 3'(y);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int lane, input int st, input int rot);
    check_value({tag, ".valid"}, 32'(outValid), 32'd1);
    check_value({tag, ".busy"},  32'(busy),     32'd1);
    check_value({tag, ".lane"},  32'(laneIdx),  32'(lane));
    check_value({tag, ".stepT"}, 32'(stepT),    32'(st));
    check_value({tag, ".rot"},   32'(rotOff),   32'(rot));
    @(negedge clk);
  endtask

  task automatic expect_done(input string tag);
    check_value({tag, ".done"},   32'(done),     32'd1);
    check_value({tag, ".dvalid"}, 32'(outValid), 32'd0);
    check_value({tag, ".dbusy"},  32'(busy),     32'd0);
    check_value({tag, ".dlane"},  32'(laneIdx),  32'd0);
    @(negedge clk);
    check_value({tag, ".done1"},  32'(done),     32'd0);
    check_value({tag, ".idlev"},  32'(outValid), 32'd0);
  endtask

  task automatic walk_033(input string tag);
    start_walk(3, 2, 1);
    expect_beat({tag, ".b0"}, 5, 2, 6);
    expect_beat({tag, ".b1"}, 2, 1, 3);
    expect_beat({tag, ".b2"}, 11, 0, 1);
    expect_done(tag);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b0;
    start    = 1'b0;
    tStart   = 5'd0;
    xInit    = 3'd0;
    yInit    = 3'd0;
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    check_value("rst.valid", 32'(outValid), 32'd0);
    check_value("rst.done",  32'(done),     32'd0);
    check_value("rst.busy",  32'(busy),     32'd0);
    check_value("rst.lane",  32'(laneIdx),  32'd0);
    check_value("rst.rot",   32'(rotOff),   32'd0);
    check_value("rst.stepT", 32'(stepT),    32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_value("idle.valid", 32'(outValid), 32'd0);

    // single beat, then back-to-back three-beat walk
    start_walk(1, 0, 2);
    expect_beat("one", 2, 0, 1);
    expect_done("one");
    walk_033("three");

    // out-of-range lengths finish without beats
    start_walk(0, 3, 3);
    expect_done("t0");
    start_walk(25, 3, 3);
    expect_done("t25");

    // start coordinates reduced modulo 5: (7,6) -> (2,1)
    start_walk(1, 7, 6);
    expect_beat("mod", 5, 0, 1);
    expect_done("mod");

    // stall on the second beat while start is held high
    start_walk(3, 2, 1);
    expect_beat("stall.b0", 5, 2, 6);
    outReady = 1'b0;
    start    = 1'b1;
    tStart   = 5'd5;
    for (int i = 0; i < 3; i++) expect_beat("stall.hold", 2, 1, 3);
    outReady = 1'b1;
    expect_beat("stall.b1", 2, 1, 3);
    start = 1'b0;
    expect_beat("stall.b2", 11, 0, 1);
    expect_done("stall");

    // maximum-length walk
    start_walk(24, 1, 1);
    check_value("max.first.stepT", 32'(stepT),  32'd23);
    check_value("max.first.rot",   32'(rotOff), 32'd44);
    for (int t = 23; t >= 0; t--) begin
      expect_beat("max", 24 - (((orb_y[t] + 2) % 5) * 5 + ((orb_x[t] + 2) % 5)), t,
                  (((t + 1) * (t + 2)) / 2) % 64);
    end
    expect_done("max");

    // reset during the second beat aborts without done
    start_walk(3, 2, 1);
    expect_beat("abort.b0", 5, 2, 6);
    check_value("abort.pre", 32'(laneIdx), 32'd2);
    rst = 1'b0;
    #1;
    check_value("abort.valid", 32'(outValid), 32'd0);
    check_value("abort.lane",  32'(laneIdx),  32'd0);
    check_value("abort.rot",   32'(rotOff),   32'd0);
    check_value("abort.stepT", 32'(stepT),    32'd0);
    check_value("abort.busy",  32'(busy),     32'd0);
    @(negedge clk);
    check_value("abort.done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_value("abort.done2", 32'(done),     32'd0);
    check_value("abort.idle",  32'(outValid), 32'd0);
    walk_033("again");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
